// File: rtl/ring_wr_cntrl.sv
// ring_wr_cntrl
//
// Write-side address and capture controller for the digitizer ring buffer.
// Incoming samples are written continuously into a 2^SIZE-deep ring. After a
// programmable pre-trigger fill, the controller arms and accepts a trigger
// rising edge. It then writes a programmable number of post-trigger samples
// and freezes. The frozen buffer is handed to the readout controller through
// last_addr, and ro_ack re-arms the capture.
//
// Parameters
//   SIZE          address width; the ring depth is 2^SIZE
//
// Ports
//   clk           system clock; all state updates on the rising edge
//   rst           synchronous active-high reset
//   enable        run control; low forces IDLE
//   din_valid     a sample is present this cycle
//   trigger       trigger input; only its rising edge is used
//   pretrig_i     minimum writes after (re)arm before a trigger is accepted
//   posttrig_i    samples written after the trigger sample; sampled at trigger
//   ro_ack        one-cycle pulse: readout complete, re-arm
//   wr_addr       RAM write address
//   wr_en         RAM write strobe (din_valid gated by the registered state)
//   last_addr     address of the most recent write (readout start address)
//   trig_addr     address of the trigger sample
//   buffer_ready  high in HOLD; the buffer is frozen and may be read
//   busy          high in FILL, ARMED or POST

module ring_wr_cntrl #(
   parameter int unsigned SIZE = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic            din_valid,
   input  logic            trigger,
   input  logic [SIZE-1:0] pretrig_i,
   input  logic [SIZE-1:0] posttrig_i,
   input  logic            ro_ack,
   output logic [SIZE-1:0] wr_addr,
   output logic            wr_en,
   output logic [SIZE-1:0] last_addr,
   output logic [SIZE-1:0] trig_addr,
   output logic            buffer_ready,
   output logic            busy
);

   localparam logic [SIZE-1:0] One = SIZE'(1);

   typedef enum logic [2:0] {
      StIdle,
      StFill,
      StArmed,
      StPost,
      StHold
   } state_e;

   state_e          r_state;
   state_e          w_state_next;

   logic [SIZE-1:0] r_wr_addr;
   logic [SIZE-1:0] r_last_addr;
   logic [SIZE-1:0] r_trig_addr;
   logic [SIZE-1:0] r_fill_cnt;
   logic [SIZE-1:0] r_post_cnt;
   logic            r_trig_q;

   logic [SIZE-1:0] w_fill_next;
   logic            w_trig_edge;
   logic            w_trig_fire;
   logic            w_wr_en;

   assign w_trig_edge = trigger & ~r_trig_q;

   // A trigger is honoured only in ARMED and only while enabled, since the
   // enable rule overrides every other transition.
   assign w_trig_fire = (r_state == StArmed) & enable & w_trig_edge;

   // Fill count including this cycle's write, saturating at all-ones. Using
   // the post-write value lets the ARMED transition happen in the cycle right
   // after the count reaches pretrig_i.
   always_comb begin
      w_fill_next = r_fill_cnt;
      if (w_wr_en && (r_fill_cnt != '1)) begin
         w_fill_next = r_fill_cnt + One;
      end
   end

   //--------------------------------------------------------------------------
   // FSM: state register
   //--------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   //--------------------------------------------------------------------------
   // FSM: next-state logic
   //--------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      if (!enable) begin
         w_state_next = StIdle;
      end else begin
         case (r_state)
            StIdle: begin
               w_state_next = StFill;
            end
            StFill: begin
               // Live comparison: a lowered pretrig_i arms immediately.
               if (w_fill_next >= pretrig_i) begin
                  w_state_next = StArmed;
               end
            end
            StArmed: begin
               if (w_trig_edge) begin
                  w_state_next = (posttrig_i == '0) ? StHold : StPost;
               end
            end
            StPost: begin
               if (w_wr_en && (r_post_cnt == One)) begin
                  w_state_next = StHold;
               end
            end
            StHold: begin
               if (ro_ack) begin
                  w_state_next = StFill;
               end
            end
            default: begin
               w_state_next = StIdle;
            end
         endcase
      end
   end

   //--------------------------------------------------------------------------
   // FSM: outputs decoded from the registered state
   //--------------------------------------------------------------------------
   always_comb begin
      w_wr_en      = 1'b0;
      busy         = 1'b0;
      buffer_ready = 1'b0;
      case (r_state)
         StFill, StArmed, StPost: begin
            w_wr_en = din_valid;
            busy    = 1'b1;
         end
         StHold: begin
            buffer_ready = 1'b1;
         end
         default: begin
            w_wr_en = 1'b0;
         end
      endcase
   end

   //--------------------------------------------------------------------------
   // Datapath: addresses, counters and trigger edge register
   //--------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_addr   <= '0;
         r_last_addr <= '0;
         r_trig_addr <= '0;
         r_fill_cnt  <= '0;
         r_post_cnt  <= '0;
         r_trig_q    <= 1'b0;
      end else begin
         r_trig_q <= trigger;

         // The write pointer only moves on writes and is never rewound by
         // state changes, so a re-armed capture continues at last_addr + 1.
         if (w_wr_en) begin
            r_last_addr <= r_wr_addr;
            r_wr_addr   <= r_wr_addr + One;
         end

         // FILL is only entered from IDLE or HOLD; clear on entry.
         if ((r_state != StFill) && (w_state_next == StFill)) begin
            r_fill_cnt <= '0;
         end else if (r_state == StFill) begin
            r_fill_cnt <= w_fill_next;
         end

         // The trigger sample is the one written this cycle if any, otherwise
         // the most recent one already in the ring.
         if (w_trig_fire) begin
            r_trig_addr <= w_wr_en ? r_wr_addr : r_last_addr;
            r_post_cnt  <= posttrig_i;
         end else if ((r_state == StPost) && w_wr_en) begin
            r_post_cnt <= r_post_cnt - One;
         end
      end
   end

   assign wr_en     = w_wr_en;
   assign wr_addr   = r_wr_addr;
   assign last_addr = r_last_addr;
   assign trig_addr = r_trig_addr;

endmodule

// File: doc/ring_wr_cntrl.md
# ring_wr_cntrl

Write-side address and capture controller for the digitizer ring buffer. It continuously writes incoming samples into the 2^SIZE-deep ring. After a programmable pre-trigger fill, it accepts a trigger and writes a programmable number of post-trigger samples. It then freezes writing and hands the buffer to the readout address controller: `last_addr` feeds that controller's `ain`, and `ro_ack` returns when readout is finished.

## Interface
- `SIZE`, 8, address width; ring depth is 2^SIZE.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `enable`  input  1  run control; low forces IDLE.
- `din_valid`  input  1  a sample is present this cycle.
- `trigger`  input  1  trigger input; only its rising edge is used.
- `pretrig_i`  input  SIZE  minimum writes after (re)arm before a trigger is accepted.
- `posttrig_i`  input  SIZE  samples written after the trigger sample; sampled at trigger.
- `ro_ack`  input  1  one-cycle pulse: readout complete, re-arm.
- `wr_addr`  output  SIZE  RAM write address.
- `wr_en`  output  1  RAM write strobe.
- `last_addr`  output  SIZE  address of the most recent write; drives the readout `ain`.
- `trig_addr`  output  SIZE  address of the trigger sample.
- `buffer_ready`  output  1  high in HOLD; buffer is frozen and may be read.
- `busy`  output  1  high in FILL, ARMED or POST.

## Operation
- States: IDLE, FILL, ARMED, POST, HOLD.
- Reset values:
  - State IDLE.
  - `wr_addr`, `last_addr` and `trig_addr` all 0.
  - `buffer_ready`, `busy` and `wr_en` all 0.
  - Fill and post counters 0; trigger edge register 0.
- `wr_en = din_valid & (state ∈ {FILL, ARMED, POST})`; this is combinational from the registered state.
- On every cycle with `wr_en` high:
  - `last_addr <= wr_addr`.
  - `wr_addr <= wr_addr + 1`, mod 2^SIZE; 2^SIZE-1 wraps to 0.
- `wr_addr` is never reset by state changes, only by `rst`. Writing resumes at `last_addr + 1`.
- Trigger edge: `trig_edge = trigger & ~trig_q`, where `trig_q` is `trigger` registered every cycle.
- Transitions (the `enable` rule has highest priority, then the others):
  - Any state, `enable == 0` → IDLE.
  - IDLE, `enable == 1` → FILL; fill counter cleared.
  - FILL: the fill counter increments on each write and saturates at 2^SIZE-1. Go to ARMED in the cycle after the counter reaches `pretrig_i`; the comparison is live. With `pretrig_i == 0`, go to ARMED on the first FILL cycle.
  - ARMED, `trig_edge`:
    - Latch `trig_addr = wr_addr` if `wr_en` is high this cycle, else `trig_addr = last_addr`.
    - Load the post counter with `posttrig_i`.
    - Next state is POST, or HOLD directly if `posttrig_i == 0`.
  - POST: each write decrements the post counter. A write while the counter equals 1 → HOLD. The trigger-cycle write is not counted.
  - HOLD, `ro_ack` → FILL; fill counter cleared.
- Triggers in IDLE, FILL, POST or HOLD are ignored and never queued. `ro_ack` outside HOLD is ignored.
- `buffer_ready` is high exactly while in HOLD. `busy` is high in FILL, ARMED and POST.
- `trig_addr` and `last_addr` are stable throughout HOLD.
- If `pretrig_i + posttrig_i + 1 > 2^SIZE`, the pre-trigger data is overwritten. No flag is raised; software must constrain the settings.

## Timing
- The state, counter and address outputs are registered. `wr_en` is combinational: `din_valid` ANDed with the registered state.
- `enable` rising in cycle N: FILL at N+1; the first possible `wr_en` is at N+1.
- Trigger edge in ARMED at cycle N: `trig_addr` is valid at N+1, and POST (or HOLD) begins at N+1.
- Final post-trigger write at cycle M: HOLD begins at M+1; `buffer_ready` = 1 and `wr_en` = 0 from M+1.
- `ro_ack` at cycle H: FILL and `busy` = 1 at H+1; `buffer_ready` = 0 at H+1.
- `rst` at any cycle, including mid-POST or mid-HOLD: all reset values take effect at the next edge.

## Test plan
- **Pre-trigger fill.** Reset, then `enable` = 1, `pretrig_i` = 4, `din_valid` held 1.
  - A trigger after 2 writes is ignored.
  - A trigger after 4 writes, at `wr_addr` = 4, is accepted: `trig_addr` = 4.
- **Post-trigger capture.** `posttrig_i` = 3, trigger while writing address 10.
  - Writes occur at 11, 12 and 13.
  - In the next cycle, HOLD: `last_addr` = 13, `trig_addr` = 10, `buffer_ready` = 1, `wr_en` = 0.
- **Wrap-around.** `posttrig_i` = 5, trigger at `wr_addr` = 253 with `din_valid` = 1.
  - Expected: `trig_addr` = 253, `last_addr` = 2, `wr_addr` = 3 in HOLD.
- **Zero post-trigger.** `posttrig_i` = 0, trigger at address 7 with `din_valid` = 1.
  - Expected: HOLD next cycle, `last_addr` = 7, `trig_addr` = 7.
  - `din_valid` gaps in POST (alternate 1/0 with `posttrig_i` = 3) still produce exactly 3 post-trigger writes.
- **Re-arm versus disable.** In HOLD:
  - `ro_ack` alone → FILL, and the next write goes to `last_addr` + 1.
  - `ro_ack` together with `enable` = 0 → IDLE; `busy` = 0 and `buffer_ready` = 0.
- **Reset during capture.** `rst` asserted mid-POST.
  - Next cycle: all outputs 0, state IDLE.
  - A trigger held high through reset does not fire until it falls and rises again in ARMED.
